alu_seq_fsm: RTL and testbench

- Parametrised ALU instruction sequencer for the microcontroller datapath.
- On a start handshake it latches one instruction word and decodes opcode, destination/source-A and source-B fields.
- It then drives one-hot register-file bus controls and ALU latch/enable strobes through a fixed read-A, read-B, compute, write-back sequence, and pulses done.
- It sits between the top-level instruction controller and the general-register/ALU bus.

---
 rtl/alu_seq_fsm_pkg.sv | 29 ++
 rtl/alu_seq_fsm_if.sv | 51 +++++
 rtl/alu_seq_fsm_reg_sel_decode.sv | 28 ++
 rtl/alu_seq_fsm.sv | 194 +++++++++++++++++++
 tb/tb_alu_seq_fsm.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_fsm_pkg.sv
// Shared types and constants for the ALU instruction sequencer.
// Instruction layout (MSB first): opcode | param1 (dest/src-A) | param2 (src-B).
package alu_seq_pkg;

  localparam int INSTR_W_DEF     = 16;
  localparam int OPC_W_DEF       = 4;
  localparam int SEL_W_DEF       = 6;
  localparam int NUM_REGS_DEF    = 4;
  localparam int ALU_OPC_MIN_DEF = 9;

  // Field offsets expressed as multiples of SEL_W from bit 0.
  localparam int P2_FIELD_IDX = 0;
  localparam int P1_FIELD_IDX = 1;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    FETCH_A = 4'd1,
    LOAD_A  = 4'd2,
    GAP     = 4'd3,
    FETCH_B = 4'd4,
    LOAD_B  = 4'd5,
    LATCH   = 4'd6,
    DRIVE   = 4'd7,
    WRITE   = 4'd8,
    DONE    = 4'd9,
    ERR     = 4'd10
  } state_t;

endpackage

// File: rtl/alu_seq_fsm_if.sv
// Handshake and register/ALU bus controls between the instruction controller
// (master) and the sequencer (slave).
// Optional macro ALU_SEQ_IMM_EN adds the immediate-operand signals.
interface alu_seq_fsm_if
  import alu_seq_pkg::*;
#(
  parameter int INSTR_W  = INSTR_W_DEF,
  parameter int OPC_W    = OPC_W_DEF,
  parameter int SEL_W    = SEL_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF
) ();

  logic                start;
  logic [INSTR_W-1:0]  instr;
  logic                busy;
  logic                done;
  logic                err;
  logic [OPC_W-1:0]    alu_op;
  logic                pc_inc;
  logic [NUM_REGS-1:0] reg_out;
  logic [NUM_REGS-1:0] reg_in;
  logic                alu_in1;
  logic                alu_in2;
  logic                alu_latch;
  logic                alu_out_en;
`ifdef ALU_SEQ_IMM_EN
  logic                imm_en;
  logic [SEL_W-2:0]    imm_val;
`endif

  modport master (
    output start, output instr,
    input  busy, input done, input err, input alu_op, input pc_inc,
    input  reg_out, input reg_in, input alu_in1, input alu_in2,
    input  alu_latch, input alu_out_en
`ifdef ALU_SEQ_IMM_EN
    , input imm_en, input imm_val
`endif
  );

  modport slave (
    input  start, input instr,
    output busy, output done, output err, output alu_op, output pc_inc,
    output reg_out, output reg_in, output alu_in1, output alu_in2,
    output alu_latch, output alu_out_en
`ifdef ALU_SEQ_IMM_EN
    , output imm_en, output imm_val
`endif
  );

endinterface

// File: rtl/alu_seq_fsm_reg_sel_decode.sv
// Register-select field decoder: one-hot enable vector plus a valid flag that
// is low when the field names a register that does not exist.
module reg_sel_decode
  import alu_seq_pkg::*;
#(
  parameter int SEL_W    = SEL_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF
) (
  input  logic [SEL_W-1:0]    i_field,
  output logic [NUM_REGS-1:0] o_onehot,
  output logic                o_valid
);

  logic [NUM_REGS-1:0] w_onehot;

  // Compare the field against every implemented register index.
  always_comb begin
    w_onehot = {NUM_REGS{1'b0}};
    for (int k = 0; k < NUM_REGS; k++) begin
      w_onehot[k] = (i_field == SEL_W'(k));
    end
  end

  // No match means the field points past the register file.
  assign o_onehot = w_onehot;
  assign o_valid  = |w_onehot;

endmodule

// File: rtl/alu_seq_fsm.sv
// ALU instruction sequencer: accepts one instruction on a start handshake and
// steps the register file / ALU through read-A, read-B, compute, write-back.
// All outputs are registered and reflect the state being entered.
// Optional macro ALU_SEQ_IMM_EN: param2 with its MSB set is an immediate,
// FETCH_B is skipped and LOAD_B drives imm_en/imm_val instead of a register.
module alu_seq_fsm
  import alu_seq_pkg::*;
#(
  parameter int INSTR_W     = INSTR_W_DEF,
  parameter int OPC_W       = OPC_W_DEF,
  parameter int SEL_W       = SEL_W_DEF,
  parameter int NUM_REGS    = NUM_REGS_DEF,
  parameter int ALU_OPC_MIN = ALU_OPC_MIN_DEF
) (
  input logic      clk,
  input logic      rst,
  alu_seq_fsm_if.slave bus
);

  state_t              r_state;
  logic [INSTR_W-1:0]  r_instr;
  logic                r_busy, r_done, r_err, r_pc_inc;
  logic [OPC_W-1:0]    r_alu_op;
  logic [NUM_REGS-1:0] r_reg_out, r_reg_in;
  logic                r_alu_in1, r_alu_in2, r_alu_latch, r_alu_out_en;
`ifdef ALU_SEQ_IMM_EN
  logic                r_imm_en;
  logic [SEL_W-2:0]    r_imm_val;
`endif

  logic [INSTR_W-1:0]  w_instr_src;
  logic [OPC_W-1:0]    w_opc;
  logic [SEL_W-1:0]    w_p1_field, w_p2_field;
  logic [NUM_REGS-1:0] w_p1_oh, w_p2_oh;
  logic                w_p1_valid, w_p2_valid, w_imm_flag;
  logic                w_accept, w_legal;

  // In IDLE the fields come straight from the bus so the first strobes can be
  // registered on the accept edge; afterwards the latched copy is used.
  assign w_instr_src = (r_state == IDLE) ? bus.instr : r_instr;
  assign w_opc       = w_instr_src[INSTR_W-1 -: OPC_W];
  assign w_p1_field  = w_instr_src[P1_FIELD_IDX*SEL_W +: SEL_W];
  assign w_p2_field  = w_instr_src[P2_FIELD_IDX*SEL_W +: SEL_W];
`ifdef ALU_SEQ_IMM_EN
  assign w_imm_flag  = w_p2_field[SEL_W-1];
`else
  assign w_imm_flag  = 1'b0;
`endif
  assign w_accept    = bus.start & (w_opc >= OPC_W'(ALU_OPC_MIN));
  assign w_legal     = w_p1_valid & (w_p2_valid | w_imm_flag);

  reg_sel_decode #(.SEL_W(SEL_W), .NUM_REGS(NUM_REGS)) u_dec_p1 (
    .i_field (w_p1_field),
    .o_onehot(w_p1_oh),
    .o_valid (w_p1_valid)
  );

  reg_sel_decode #(.SEL_W(SEL_W), .NUM_REGS(NUM_REGS)) u_dec_p2 (
    .i_field (w_p2_field),
    .o_onehot(w_p2_oh),
    .o_valid (w_p2_valid)
  );

  // Sequencer state plus registered strobes for the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_instr      <= {INSTR_W{1'b0}};
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_pc_inc     <= 1'b0;
      r_alu_op     <= {OPC_W{1'b0}};
      r_reg_out    <= {NUM_REGS{1'b0}};
      r_reg_in     <= {NUM_REGS{1'b0}};
      r_alu_in1    <= 1'b0;
      r_alu_in2    <= 1'b0;
      r_alu_latch  <= 1'b0;
      r_alu_out_en <= 1'b0;
`ifdef ALU_SEQ_IMM_EN
      r_imm_en     <= 1'b0;
      r_imm_val    <= {(SEL_W-1){1'b0}};
`endif
    end else begin
      // Strobes default low; busy stays high until a terminal state exits.
      r_busy       <= 1'b1;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_pc_inc     <= 1'b0;
      r_reg_out    <= {NUM_REGS{1'b0}};
      r_reg_in     <= {NUM_REGS{1'b0}};
      r_alu_in1    <= 1'b0;
      r_alu_in2    <= 1'b0;
      r_alu_latch  <= 1'b0;
      r_alu_out_en <= 1'b0;
`ifdef ALU_SEQ_IMM_EN
      r_imm_en     <= 1'b0;
      r_imm_val    <= {(SEL_W-1){1'b0}};
`endif
      case (r_state)
        IDLE: begin
          if (w_accept && w_legal) begin
            r_state   <= FETCH_A;
            r_instr   <= bus.instr;
            r_alu_op  <= w_opc;
            r_pc_inc  <= 1'b1;
            r_reg_out <= w_p1_oh;
          end else if (w_accept) begin
            r_state   <= ERR;
            r_instr   <= bus.instr;
            r_alu_op  <= w_opc;
            r_pc_inc  <= 1'b1;
            r_done    <= 1'b1;
            r_err     <= 1'b1;
          end else begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_alu_op  <= {OPC_W{1'b0}};
          end
        end
        FETCH_A: begin
          r_state   <= LOAD_A;
          r_reg_out <= w_p1_oh;
          r_alu_in1 <= 1'b1;
        end
        LOAD_A: begin
          r_state <= GAP;
        end
        GAP: begin
          if (w_imm_flag) begin
            r_state   <= LOAD_B;
            r_alu_in2 <= 1'b1;
`ifdef ALU_SEQ_IMM_EN
            r_imm_en  <= 1'b1;
            r_imm_val <= w_p2_field[SEL_W-2:0];
`endif
          end else begin
            r_state   <= FETCH_B;
            r_reg_out <= w_p2_oh;
          end
        end
        FETCH_B: begin
          r_state   <= LOAD_B;
          r_reg_out <= w_p2_oh;
          r_alu_in2 <= 1'b1;
        end
        LOAD_B: begin
          r_state     <= LATCH;
          r_alu_latch <= 1'b1;
        end
        LATCH: begin
          r_state      <= DRIVE;
          r_alu_out_en <= 1'b1;
        end
        DRIVE: begin
          r_state      <= WRITE;
          r_alu_out_en <= 1'b1;
          r_reg_in     <= w_p1_oh;
        end
        WRITE: begin
          r_state <= DONE;
          r_done  <= 1'b1;
        end
        DONE, ERR: begin
          r_state  <= IDLE;
          r_busy   <= 1'b0;
          r_alu_op <= {OPC_W{1'b0}};
        end
        default: begin
          r_state  <= IDLE;
          r_busy   <= 1'b0;
          r_alu_op <= {OPC_W{1'b0}};
        end
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.err        = r_err;
  assign bus.alu_op     = r_alu_op;
  assign bus.pc_inc     = r_pc_inc;
  assign bus.reg_out    = r_reg_out;
  assign bus.reg_in     = r_reg_in;
  assign bus.alu_in1    = r_alu_in1;
  assign bus.alu_in2    = r_alu_in2;
  assign bus.alu_latch  = r_alu_latch;
  assign bus.alu_out_en = r_alu_out_en;
`ifdef ALU_SEQ_IMM_EN
  assign bus.imm_en     = r_imm_en;
  assign bus.imm_val    = r_imm_val;
`endif

endmodule

// File: tb/tb_alu_seq_fsm.sv
// Directed, table-driven bench for alu_seq_fsm. Expected output words are
// hand-written per cycle; cycle n is the n-th cycle after the accept edge.
module tb_alu_seq_fsm;
  import alu_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_seq_fsm_if #(.INSTR_W(16), .OPC_W(4), .SEL_W(6), .NUM_REGS(4)) bus ();

  alu_seq_fsm #(.INSTR_W(16), .OPC_W(4), .SEL_W(6), .NUM_REGS(4), .ALU_OPC_MIN(9)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Output word: busy done err pc_inc alu_in1 alu_in2 alu_latch alu_out_en | reg_out | reg_in | alu_op
  localparam logic [19:0] B_BUSY = 20'h80000;
  localparam logic [19:0] B_DONE = 20'h40000;
  localparam logic [19:0] B_ERR  = 20'h20000;
  localparam logic [19:0] B_PC   = 20'h10000;
  localparam logic [19:0] B_A1   = 20'h08000;
  localparam logic [19:0] B_A2   = 20'h04000;
  localparam logic [19:0] B_LAT  = 20'h02000;
  localparam logic [19:0] B_OE   = 20'h01000;
  localparam logic [19:0] Z      = 20'h00000;

  typedef struct {
    string       name;
    logic [15:0] instr;
    int          cyc;
    logic [19:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [19:0] obs[0:11];
`ifdef ALU_SEQ_IMM_EN
  logic [5:0]  imm_obs[0:11];
`endif
  int n_total = 0;
  int n_pass  = 0;
  int n_done;
  int n_bus_bad = 0;
  int n_seen;

  function automatic logic [19:0] rf(input logic [3:0] ro, input logic [3:0] ri, input logic [3:0] op);
    return {8'h00, ro, ri, op};
  endfunction

  function automatic logic [19:0] pack();
    return {bus.busy, bus.done, bus.err, bus.pc_inc, bus.alu_in1, bus.alu_in2,
            bus.alu_latch, bus.alu_out_en, bus.reg_out, bus.reg_in, bus.alu_op};
  endfunction

  function automatic void add(input string nm, input logic [15:0] ins, input int cyc, input logic [19:0] e);
    vec_t v;
    v.name  = nm;
    v.instr = ins;
    v.cyc   = cyc;
    v.exp   = e;
    vecs.push_back(v);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // One start pulse, then 11 sampled cycles; optional second start in inj_cyc.
  task automatic run(input logic [15:0] ins, input int inj_cyc, input logic [15:0] inj_ins);
    @(negedge clk);
    bus.instr = ins;
    bus.start = 1'b1;
    obs[0] = pack();
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n_done = 0;
    for (int c = 1; c < 12; c++) begin
      if (c == inj_cyc) begin
        bus.start = 1'b1;
        bus.instr = inj_ins;
      end
      @(negedge clk);
      obs[c] = pack();
`ifdef ALU_SEQ_IMM_EN
      imm_obs[c] = {bus.imm_en, bus.imm_val};
`endif
      if (bus.done) n_done++;
      if ((bus.reg_out != 4'b0000 && bus.reg_in != 4'b0000) ||
          !$onehot0(bus.reg_out) || !$onehot0(bus.reg_in)) n_bus_bad++;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
    end
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.instr = 16'h0000;
    #12;
    check("reset outputs", {12'h000, pack()}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Legal op p1=1 p2=2
    add("legal", 16'h9042, 0, Z);
    add("legal", 16'h9042, 1, B_BUSY | B_PC  | rf(4'b0010, 4'b0000, 4'h9));
    add("legal", 16'h9042, 2, B_BUSY | B_A1  | rf(4'b0010, 4'b0000, 4'h9));
    add("legal", 16'h9042, 3, B_BUSY         | rf(4'b0000, 4'b0000, 4'h9));
    add("legal", 16'h9042, 4, B_BUSY         | rf(4'b0100, 4'b0000, 4'h9));
    add("legal", 16'h9042, 5, B_BUSY | B_A2  | rf(4'b0100, 4'b0000, 4'h9));
    add("legal", 16'h9042, 6, B_BUSY | B_LAT | rf(4'b0000, 4'b0000, 4'h9));
    add("legal", 16'h9042, 7, B_BUSY | B_OE  | rf(4'b0000, 4'b0000, 4'h9));
    add("legal", 16'h9042, 8, B_BUSY | B_OE  | rf(4'b0000, 4'b0010, 4'h9));
    add("legal", 16'h9042, 9, B_BUSY | B_DONE| rf(4'b0000, 4'b0000, 4'h9));
    add("legal", 16'h9042, 10, Z);
    // Non-ALU opcodes are ignored
    add("nonalu", 16'h3042, 1, Z);
    add("nonalu", 16'h3042, 9, Z);
    add("opc8", 16'h8042, 1, Z);
    add("opc8", 16'h8042, 9, Z);
    // Illegal p1 and illegal p2
    add("bad_p1", 16'hA105, 1, B_BUSY | B_PC | B_DONE | B_ERR | rf(4'b0000, 4'b0000, 4'hA));
    add("bad_p1", 16'hA105, 2, Z);
    add("bad_p2", 16'h9047, 1, B_BUSY | B_PC | B_DONE | B_ERR | rf(4'b0000, 4'b0000, 4'h9));
    add("bad_p2", 16'h9047, 2, Z);
    // Highest opcode, highest register
    add("top", 16'hF0C3, 1, B_BUSY | B_PC  | rf(4'b1000, 4'b0000, 4'hF));
    add("top", 16'hF0C3, 5, B_BUSY | B_A2  | rf(4'b1000, 4'b0000, 4'hF));
    add("top", 16'hF0C3, 8, B_BUSY | B_OE  | rf(4'b0000, 4'b1000, 4'hF));
    add("top", 16'hF0C3, 9, B_BUSY | B_DONE| rf(4'b0000, 4'b0000, 4'hF));
`ifdef ALU_SEQ_IMM_EN
    add("imm", 16'hB0A5, 1, B_BUSY | B_PC  | rf(4'b0100, 4'b0000, 4'hB));
    add("imm", 16'hB0A5, 3, B_BUSY         | rf(4'b0000, 4'b0000, 4'hB));
    add("imm", 16'hB0A5, 4, B_BUSY | B_A2  | rf(4'b0000, 4'b0000, 4'hB));
    add("imm", 16'hB0A5, 7, B_BUSY | B_OE  | rf(4'b0000, 4'b0100, 4'hB));
    add("imm", 16'hB0A5, 8, B_BUSY | B_DONE| rf(4'b0000, 4'b0000, 4'hB));
    add("imm", 16'hB0A5, 9, Z);
`else
    add("imm_err", 16'hB0A5, 1, B_BUSY | B_PC | B_DONE | B_ERR | rf(4'b0000, 4'b0000, 4'hB));
    add("imm_err", 16'hB0A5, 2, Z);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      if (i == 0 || vecs[i].instr != vecs[i-1].instr) run(vecs[i].instr, 0, 16'h0000);
      check($sformatf("%s c%0d", vecs[i].name, vecs[i].cyc), {12'h000, obs[vecs[i].cyc]}, {12'h000, vecs[i].exp});
    end
    check("bus onehot/exclusive", n_bus_bad, 0);

    // Second start during cycle 5 must not disturb the running sequence
    run(16'h9042, 5, 16'hA105);
    check("busy_ign c5",  {12'h000, obs[5]},  {12'h000, B_BUSY | B_A2 | rf(4'b0100, 4'b0000, 4'h9)});
    check("busy_ign c7",  {12'h000, obs[7]},  {12'h000, B_BUSY | B_OE | rf(4'b0000, 4'b0000, 4'h9)});
    check("busy_ign c8",  {12'h000, obs[8]},  {12'h000, B_BUSY | B_OE | rf(4'b0000, 4'b0010, 4'h9)});
    check("busy_ign c9",  {12'h000, obs[9]},  {12'h000, B_BUSY | B_DONE | rf(4'b0000, 4'b0000, 4'h9)});
    check("busy_ign c11", {12'h000, obs[11]}, 32'h0);
    check("busy_ign done count", n_done, 1);

`ifdef ALU_SEQ_IMM_EN
    run(16'hB0A5, 0, 16'h0000);
    check("imm c3 imm", {26'h0, imm_obs[3]}, 32'h0);
    check("imm c4 imm", {26'h0, imm_obs[4]}, {26'h0, 1'b1, 5'd5});
    check("imm c5 imm", {26'h0, imm_obs[5]}, 32'h0);
    check("imm done count", n_done, 1);
`else
    run(16'hB0A5, 0, 16'h0000);
    check("imm_err done count", n_done, 1);
`endif

    // Reset asserted while in LATCH aborts at once
    @(negedge clk);
    bus.instr = 16'h9042;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid_rst latch", {12'h000, pack()}, {12'h000, B_BUSY | B_LAT | rf(4'b0000, 4'b0000, 4'h9)});
    rst = 1'b1;
    #1;
    check("mid_rst abort", {12'h000, pack()}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    n_seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (pack() != Z) n_seen++;
    end
    check("mid_rst quiet", n_seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
